// File: rtl/sum_nbit_serial_pkg.sv
// Shared definitions for the chunk-serial adder/subtractor: FSM state
// encoding and elaboration-time parameter helpers.
package sum_pkg;

   // FSM state encoding. Kept as plain localparams so the encoding is
   // fixed and visible on the debug state output.
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   // A configuration is legal when the operand splits into whole chunks.
   function automatic bit chunk_cfg_ok(input int width, input int chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

   // Bits needed to count chunks 0..nchunk-1. Never narrower than one bit,
   // so a single-chunk build still has a legal counter.
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

   // Bits needed to address any bit position of a width-bit word.
   function automatic int bit_index_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/sum_nbit_serial_if.sv
// Bus interface between a requester and sum_nbit_serial.
//
// Handshake: the requester raises start with sub/a/b/cin valid. The
// request is accepted only on a rising edge where the unit is idle (busy=0
// and done=0); a start seen while busy or done is dropped, not queued.
// Operands are captured on the accepting edge and may change afterwards.
// busy is high for every chunk cycle of the operation. done is a one-cycle
// pulse; sum/cout/ovf are valid from that cycle and hold until the next
// operation completes. state mirrors the FSM for observation only.
interface sum_nbit_serial_if
   import sum_pkg::*;
#(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   state_t           state;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, ovf, state
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, ovf, state
   );

endinterface

// File: rtl/sum_nbit_serial_chunk.sv
// CHUNK-bit combinational ripple-carry adder, the single arithmetic block
// shared by every cycle of a serial operation. Also exports the carry into
// its top bit so the caller can form signed overflow on the last chunk.
module sum_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   // w_c[i] is the carry into bit i; w_c[CHUNK] is the carry out.
   logic [CHUNK:0] w_c;

   assign w_c[0] = cin;

   for (genvar g = 0; g < CHUNK; g++) begin : g_fa
      assign s[g]     = a[g] ^ b[g] ^ w_c[g];
      assign w_c[g+1] = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
   end

   assign cout = w_c[CHUNK];
   assign cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/sum_nbit_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor. One CHUNK-bit slice is added per
// clock, least significant slice first, through one shared sum_chunk.
// Subtraction is a + ~b + 1: b is inverted and the carry seeded with 1 at
// capture time, so the run phase is identical for both modes.
module sum_nbit_serial
   import sum_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic               clk,
   input  logic               rst,
   sum_nbit_serial_if.slave   bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = idx_width(NCHUNK);
   localparam int BW     = bit_index_width(WIDTH);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   // Refuse to build an operand that does not split into whole chunks.
   if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_error
      $error("sum_nbit_serial: WIDTH (%0d) must be a multiple of CHUNK (%0d), 1 <= CHUNK <= WIDTH",
             WIDTH, CHUNK);
   end

   // FSM
   state_t r_state;
   state_t w_next_state;

   // Operand, partial-sum and carry registers
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   logic             r_carry;
   logic [IDXW-1:0]  r_idx;

   // Result registers, held between completions
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   // FSM decode
   logic w_busy;
   logic w_done;
   logic w_capture;
   logic w_step;
   logic w_finish;

   // Chunk datapath
   logic [BW-1:0]    w_base;
   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CHUNK-1:0] w_s_chunk;
   logic             w_chunk_cout;
   logic             w_chunk_cmsb;
   logic [WIDTH-1:0] w_s_full;

   // State register: reset always lands in IDLE, abandoning any operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: accept in IDLE, walk the chunks in RUN, one cycle of DONE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_next_state = RUN;
            end
         end
         RUN: begin
            if (r_idx == LAST_IDX) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Output decode: status flags and datapath strobes from the current state.
   always_comb begin
      w_busy    = 1'b0;
      w_done    = 1'b0;
      w_capture = 1'b0;
      w_step    = 1'b0;
      w_finish  = 1'b0;
      case (r_state)
         IDLE: begin
            w_capture = bus.start;
         end
         RUN: begin
            w_busy   = 1'b1;
            w_step   = 1'b1;
            w_finish = (r_idx == LAST_IDX);
         end
         DONE: begin
            w_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Bit offset of the chunk being processed this cycle.
   assign w_base    = BW'(int'(r_idx) * CHUNK);
   assign w_a_chunk = r_a[w_base +: CHUNK];
   assign w_b_chunk = r_b[w_base +: CHUNK];

   sum_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a    (w_a_chunk),
      .b    (w_b_chunk),
      .cin  (r_carry),
      .s    (w_s_chunk),
      .cout (w_chunk_cout),
      .cmsb (w_chunk_cmsb)
   );

   // Partial sum with this cycle's chunk merged in; on the last chunk this
   // is the complete result, so it can be loaded straight into r_sum.
   always_comb begin
      w_s_full                   = r_s;
      w_s_full[w_base +: CHUNK]  = w_s_chunk;
   end

   // Operand capture and chunk stepping. The operands keep their captured
   // value for the whole run, so later bus changes cannot leak in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
      end else if (w_capture) begin
         r_a     <= bus.a;
         r_b     <= bus.b ^ {WIDTH{bus.sub}};
         r_carry <= bus.sub | bus.cin;
         r_idx   <= '0;
      end else if (w_step) begin
         r_s     <= w_s_full;
         r_carry <= w_chunk_cout;
         r_idx   <= w_finish ? '0 : r_idx + 1'b1;
      end
   end

   // Result registers: loaded only on the edge that enters DONE, so they
   // hold the previous result for the whole of the next run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_finish) begin
         r_sum  <= w_s_full;
         r_cout <= w_chunk_cout;
         r_ovf  <= w_chunk_cout ^ w_chunk_cmsb;
      end
   end

   assign bus.busy  = w_busy;
   assign bus.done  = w_done;
   assign bus.sum   = r_sum;
   assign bus.cout  = r_cout;
   assign bus.ovf   = r_ovf;
   assign bus.state = r_state;

endmodule

// File: tb/tb_sum_nbit_serial.sv
// Bench for sum_nbit_serial: three instances (CHUNK = 4, 1 and 16, all
// WIDTH = 16) share one clock and reset. Directed vectors come from a
// table, the multi-cycle corner cases are hand-written sequences, and every
// done pulse is checked against a per-instance expected queue.
module tb_sum_nbit_serial;
   import sum_pkg::*;

   localparam int W = 16;

   typedef struct {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] e_sum;
      logic         e_cout;
      logic         e_ovf;
   } vec_t;

   typedef struct packed {
      logic         busy;
      logic         done;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic [1:0]   state;
   } obs_t;

   logic clk;
   logic rst;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected {sum, cout, ovf} per instance: 0 = CHUNK 4, 1 = CHUNK 1, 2 = CHUNK 16
   logic [W+1:0] exp_q0[$];
   logic [W+1:0] exp_q1[$];
   logic [W+1:0] exp_q2[$];

   logic [W-1:0] prev_sum[3];

   sum_nbit_serial_if #(.WIDTH(W)) bus0 ();
   sum_nbit_serial_if #(.WIDTH(W)) bus1 ();
   sum_nbit_serial_if #(.WIDTH(W)) bus2 ();

   sum_nbit_serial #(.WIDTH(W), .CHUNK(4))  u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   sum_nbit_serial #(.WIDTH(W), .CHUNK(1))  u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   sum_nbit_serial #(.WIDTH(W), .CHUNK(16)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference arithmetic, written from the unsigned/signed definitions.
   function automatic logic [W+1:0] model(input logic sub, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
      logic [W:0]   full;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      if (sub) begin
         full = {1'b0, a} - {1'b0, b};
         s    = full[W-1:0];
         co   = (a >= b);
         ov   = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end else begin
         full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         s    = full[W-1:0];
         co   = full[W];
         ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      return {s, co, ov};
   endfunction

   function automatic int nchunk_of(input int which);
      case (which)
         0:       return 4;
         1:       return 16;
         default: return 1;
      endcase
   endfunction

   function automatic obs_t get_obs(input int which);
      obs_t o;
      case (which)
         0:       o = '{bus0.busy, bus0.done, bus0.sum, bus0.cout, bus0.ovf, bus0.state};
         1:       o = '{bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.ovf, bus1.state};
         default: o = '{bus2.busy, bus2.done, bus2.sum, bus2.cout, bus2.ovf, bus2.state};
      endcase
      return o;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input int which, input logic st, input logic sub,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      case (which)
         0: begin bus0.start = st; bus0.sub = sub; bus0.a = a; bus0.b = b; bus0.cin = cin; end
         1: begin bus1.start = st; bus1.sub = sub; bus1.a = a; bus1.b = b; bus1.cin = cin; end
         default: begin bus2.start = st; bus2.sub = sub; bus2.a = a; bus2.b = b; bus2.cin = cin; end
      endcase
   endtask

   task automatic set_start(input int which, input logic st);
      case (which)
         0:       bus0.start = st;
         1:       bus1.start = st;
         default: bus2.start = st;
      endcase
   endtask

   task automatic push_exp(input int which, input logic [W+1:0] e);
      case (which)
         0:       exp_q0.push_back(e);
         1:       exp_q1.push_back(e);
         default: exp_q2.push_back(e);
      endcase
   endtask

   task automatic wait_idle(input int which);
      obs_t o;
      bit   ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         o = get_obs(which);
         if (o.state == IDLE && !o.busy && !o.done) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_wait", 32'(ok), 32'd1);
   endtask

   // One operation, observed at every falling edge. Optionally pulses start
   // with other operands after busy sample inj_at, or asserts reset after
   // busy sample rst_at.
   task automatic run_op(input int which, input logic sub, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin,
                         input int inj_at, input int rst_at,
                         output int busy_n, output int done_n,
                         output logic [W-1:0] first_busy_sum, output logic [W+1:0] res);
      obs_t o;
      int   n = nchunk_of(which);
      busy_n         = 0;
      done_n         = 0;
      first_busy_sum = '0;
      res            = '0;
      wait_idle(which);
      drive(which, 1'b1, sub, a, b, cin);
      push_exp(which, model(sub, a, b, cin));
      for (int cyc = 0; cyc < n + 8; cyc++) begin
         @(negedge clk);
         set_start(which, 1'b0);
         if (rst) rst = 1'b0;
         o = get_obs(which);
         if (o.busy) begin
            if (busy_n == 0) first_busy_sum = o.sum;
            busy_n++;
            if (busy_n == inj_at) begin
               drive(which, 1'b1, ~sub, 16'hAAAA, 16'h5555, ~cin);
            end
            if (busy_n == rst_at) begin
               rst = 1'b1;
               #1;
               o = get_obs(which);
               check("rst_busy",  32'(o.busy),  32'd0);
               check("rst_done",  32'(o.done),  32'd0);
               check("rst_sum",   32'(o.sum),   32'd0);
               check("rst_cout",  32'(o.cout),  32'd0);
               check("rst_ovf",   32'(o.ovf),   32'd0);
               check("rst_state", 32'(o.state), 32'(IDLE));
               exp_q0.delete();
               exp_q1.delete();
               exp_q2.delete();
               prev_sum[0] = '0;
               prev_sum[1] = '0;
               prev_sum[2] = '0;
            end
         end
         if (o.done) begin
            done_n++;
            res = {o.sum, o.cout, o.ovf};
         end
      end
   endtask

   // Hold start high for k operations; a new operand set is presented in
   // each done cycle so it is picked up by the next IDLE cycle.
   task automatic run_b2b(input int which, input int k);
      obs_t         o;
      int           n    = nchunk_of(which);
      int           got  = 0;
      int           last = 0;
      logic         sub;
      logic         cin;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W+1:0] e;
      wait_idle(which);
      sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
      e = model(sub, a, b, cin);
      drive(which, 1'b1, sub, a, b, cin);
      push_exp(which, e);
      for (int cyc = 0; cyc < (k + 1) * (n + 2) + 10 && got < k; cyc++) begin
         @(negedge clk);
         o = get_obs(which);
         if (o.done) begin
            if (got > 0) check("b2b_period", 32'(cyc - last), 32'(n + 2));
            last = cyc;
            got++;
            prev_sum[which] = e[W+1:2];
            if (got < k) begin
               sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
               a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
               e = model(sub, a, b, cin);
               drive(which, 1'b1, sub, a, b, cin);
               push_exp(which, e);
            end else begin
               set_start(which, 1'b0);
            end
         end
      end
      set_start(which, 1'b0);
      check("b2b_count", 32'(got), 32'(k));
   endtask

   // ---------------- scoreboard ----------------
   // Every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus0.done) begin
         if (exp_q0.size() == 0) check("sb0_unexpected_done", 32'd1, 32'd0);
         else check("sb0_result", 32'({bus0.sum, bus0.cout, bus0.ovf}), 32'(exp_q0.pop_front()));
      end
      if (bus1.done) begin
         if (exp_q1.size() == 0) check("sb1_unexpected_done", 32'd1, 32'd0);
         else check("sb1_result", 32'({bus1.sum, bus1.cout, bus1.ovf}), 32'(exp_q1.pop_front()));
      end
      if (bus2.done) begin
         if (exp_q2.size() == 0) check("sb2_unexpected_done", 32'd1, 32'd0);
         else check("sb2_result", 32'({bus2.sum, bus2.cout, bus2.ovf}), 32'(exp_q2.pop_front()));
      end
   end

   // ---------------- test sequence ----------------
   vec_t tbl[10];

   initial begin
      obs_t         o;
      int           busy_n;
      int           done_n;
      logic [W-1:0] fbs;
      logic [W+1:0] res;
      logic         sub;
      logic         cin;
      logic [W-1:0] a;
      logic [W-1:0] b;

      tbl[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[7] = '{1'b1, 16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[8] = '{1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0};
      tbl[9] = '{1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b1, 1'b0};

      for (int w = 0; w < 3; w++) begin
         drive(w, 1'b0, 1'b0, '0, '0, 1'b0);
         prev_sum[w] = '0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      o = get_obs(0);
      check("reset_state", 32'(o.state), 32'(IDLE));
      check("reset_busy",  32'(o.busy),  32'd0);
      check("reset_done",  32'(o.done),  32'd0);
      check("reset_sum",   32'(o.sum),   32'd0);
      check("reset_cout",  32'(o.cout),  32'd0);
      check("reset_ovf",   32'(o.ovf),   32'd0);
      check("reset_sum_c1",  32'(get_obs(1).sum), 32'd0);
      check("reset_sum_c16", 32'(get_obs(2).sum), 32'd0);

      // Directed table on all three chunk sizes
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < 10; i++) begin
            run_op(w, tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, -1, -1,
                   busy_n, done_n, fbs, res);
            check("tbl_busy_cycles", 32'(busy_n), 32'(nchunk_of(w)));
            check("tbl_done_pulses", 32'(done_n), 32'd1);
            check("tbl_hold_sum",    32'(fbs),    32'(prev_sum[w]));
            check("tbl_result", 32'(res), 32'({tbl[i].e_sum, tbl[i].e_cout, tbl[i].e_ovf}));
            prev_sum[w] = tbl[i].e_sum;
         end
      end

      // start pulsed in RUN cycle 2 with other operands: ignored
      run_op(0, 1'b0, 16'h1111, 16'h2222, 1'b0, 2, -1, busy_n, done_n, fbs, res);
      check("ign_busy_cycles", 32'(busy_n), 32'd4);
      check("ign_done_pulses", 32'(done_n), 32'd1);
      check("ign_result",      32'(res),    32'({16'h3333, 1'b0, 1'b0}));
      prev_sum[0] = 16'h3333;

      // Reset in RUN cycle 3: no done, then a fresh operation completes
      run_op(0, 1'b0, 16'hF0F0, 16'h0F0F, 1'b1, -1, 3, busy_n, done_n, fbs, res);
      check("rst_done_pulses", 32'(done_n), 32'd0);
      run_op(0, 1'b0, 16'hF0F0, 16'h0F0F, 1'b1, -1, -1, busy_n, done_n, fbs, res);
      check("post_rst_busy",   32'(busy_n), 32'd4);
      check("post_rst_done",   32'(done_n), 32'd1);
      check("post_rst_hold",   32'(fbs),    32'd0);
      check("post_rst_result", 32'(res),    32'({16'h0000, 1'b1, 1'b0}));
      prev_sum[0] = 16'h0000;

      // Random operations on the single-bit and full-width builds
      for (int w = 1; w < 3; w++) begin
         for (int i = 0; i < 12; i++) begin
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            a   = 16'($urandom_range(0, 65535));
            b   = 16'($urandom_range(0, 65535));
            run_op(w, sub, a, b, cin, -1, -1, busy_n, done_n, fbs, res);
            check("rnd_busy_cycles", 32'(busy_n), 32'(nchunk_of(w)));
            check("rnd_done_pulses", 32'(done_n), 32'd1);
            check("rnd_hold_sum",    32'(fbs),    32'(prev_sum[w]));
            prev_sum[w] = res[W+1:2];
         end
      end

      // start held high: back-to-back operations
      run_b2b(0, 4);
      run_b2b(1, 3);
      run_b2b(2, 5);

      repeat (25) @(negedge clk);
      check("q0_drained", 32'(exp_q0.size()), 32'd0);
      check("q1_drained", 32'(exp_q1.size()), 32'd0);
      check("q2_drained", 32'(exp_q2.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
